// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone B4 single-port RAM responder with classic cycles and incrementing bursts.
// Define WB_RAM_SLAVE_RETRY_EN to add a busy input that turns the first termination of a cycle into RTY.
module wb_ram_slave #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef WB_RAM_SLAVE_RETRY_EN
    input  logic        busy,
`endif
    input  logic        CYC,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] ADR,
    input  logic [31:0] DAT_O,
    input  logic [2:0]  CTI_O,
    output logic [31:0] DAT_I,
    output logic        ACK,
    output logic        ERR,
    output logic        RTY
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, BURST} state_t;
    typedef enum logic [1:0] {R_NONE, R_ACK, R_ERR, R_RTY} resp_t;

    state_t      state;
    resp_t       resp;
    logic [3:0]  cnt;
    logic [AW:0] baddr;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] off;
    logic        in_range, hold, enter, beat, past_end, wr;
    logic [AW-1:0] idx, ba_nxt, wr_addr;

`ifdef WB_RAM_SLAVE_RETRY_EN
    assign hold = busy;
    assign RTY  = CYC && state == RESP && resp == R_RTY;
`else
    assign hold = 1'b0;
    assign RTY  = 1'b0;
`endif

    // Subtracting the base first makes addresses below the window wrap to huge offsets.
    assign off      = ADR - BASE_ADDR;
    assign in_range = off < SPAN;
    assign idx      = off[AW+1:2];
    assign ba_nxt   = baddr[AW-1:0] + AW'(1);
    assign enter    = CYC && (state == IDLE ? STB && WAIT_STATES == 0 : state == WAIT && cnt == 4'd1);
    assign beat     = CYC && STB && state == BURST;
    assign past_end = baddr[AW];
    assign wr       = !rst && WE && (enter ? in_range && !hold : beat && !past_end);
    assign wr_addr  = state == BURST ? baddr[AW-1:0] : idx;
    assign ACK      = CYC && (state == RESP ? resp == R_ACK : beat && !past_end);
    assign ERR      = CYC && (state == RESP ? resp == R_ERR : beat && past_end);

    always_ff @(posedge clk) begin
        if (wr) mem[wr_addr] <= DAT_O;
    end

    // DAT_I always holds the word for the next beat, so burst beats need no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            resp  <= R_NONE;
            cnt   <= '0;
            baddr <= '0;
            DAT_I <= '0;
        end else if (!CYC) begin
            state <= IDLE;
        end else if (enter) begin
            state <= RESP;
            resp  <= !in_range ? R_ERR : hold ? R_RTY : R_ACK;
            baddr <= {1'b0, idx};
            DAT_I <= mem[idx];
        end else if (state == IDLE && STB) begin
            state <= WAIT;
            cnt   <= 4'(WAIT_STATES);
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end else if (state == RESP || beat) begin
            state <= (state == RESP ? resp == R_ACK && STB : !past_end) && CTI_O == 3'b010 ? BURST : IDLE;
            baddr <= baddr + (AW+1)'(1);
            DAT_I <= mem[ba_nxt];
        end
    end
endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: classic-cycle vector table plus burst, abort and reset sequences, scored against a queue.
module tb_wb_ram_slave;
    logic        clk = 0, rst = 1, STB = 0, WE = 0;
    logic [31:0] ADR = 0, DAT_O = 0;
    logic [2:0]  CTI_O = 0, cyc = 0, ack, err, rty;
    logic [31:0] dat [3];
    int          chk_cnt = 0, pass_cnt = 0;

    typedef struct { logic [1:0] kind; logic chk; logic [31:0] data; int cyc; } exp_t;
    typedef struct { int d; logic we; logic [31:0] adr; logic [31:0] dat; logic [1:0] kind; logic [31:0] exp; int lat; } vec_t;
    exp_t sb[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        wb_ram_slave #(.WAIT_STATES(i == 0 ? 0 : i == 1 ? 3 : 5)) u (
            .clk(clk), .rst(rst),
`ifdef WB_RAM_SLAVE_RETRY_EN
            .busy(1'b0),
`endif
            .CYC(cyc[i]), .STB(STB), .WE(WE), .ADR(ADR), .DAT_O(DAT_O), .CTI_O(CTI_O),
            .DAT_I(dat[i]), .ACK(ack[i]), .ERR(err[i]), .RTY(rty[i])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [1:0] term(input int d);
        return ack[d] ? 2'd1 : err[d] ? 2'd2 : rty[d] ? 2'd3 : 2'd0;
    endfunction

    task automatic score(input int d, input int t);
        exp_t e;
        if (sb.size() == 0) begin
            chk_cnt++;
            $display("FAIL sb_empty: got termination %0d expected none", term(d));
            return;
        end
        e = sb.pop_front();
        check("term_kind", 32'(term(d)), 32'(e.kind));
        check("term_cycle", 32'(t), 32'(e.cyc));
        check("one_hot", 32'($countones({ack[d], err[d], rty[d]})), 1);
        if (e.chk) check("rd_data", dat[d], e.data);
    endtask

    task automatic classic(input vec_t v);
        int t = 0;
        sb.push_back(exp_t'{v.kind, !v.we && v.kind == 2'd1, v.exp, v.lat});
        @(posedge clk); #1;
        cyc[v.d] = 1; STB = 1; WE = v.we; ADR = v.adr; DAT_O = v.dat; CTI_O = 3'b000;
        @(negedge clk);
        while (term(v.d) == 0 && t < 40) begin @(negedge clk); t++; end
        if (term(v.d) == 0) begin
            chk_cnt++;
            $display("FAIL classic_timeout: no termination for adr %h, required one", v.adr);
            sb.delete();
        end else score(v.d, t);
        @(posedge clk); #1; STB = 0;
        @(negedge clk); check("classic_single", 32'(term(v.d)), 0);
        @(posedge clk); #1; cyc[v.d] = 0;
    endtask

    task automatic drive_beat(input logic [31:0] adr, input int k, input int nb, input logic [31:0] dbase);
        STB = 1; ADR = adr + 32'(4 * k); DAT_O = dbase + 32'(k);
        CTI_O = k == nb - 1 ? 3'b111 : 3'b010;
    endtask

    // gap > 0 drops STB for two cycles before beat index gap; beats from nok on expect ERR.
    task automatic burst(input int d, input logic we, input logic [31:0] adr, input int nb, input int nok,
                         input int gap, input logic [31:0] dbase);
        int t = 0, k = 0, gl = 0;
        bit done = 0, gapped = 0, hit;
        for (int i = 0; i < nb && i <= nok; i++)
            sb.push_back(exp_t'{i < nok ? 2'd1 : 2'd2, !we && i < nok, dbase + 32'(i),
                                i + 1 + ((gap > 0 && i >= gap) ? 2 : 0)});
        @(posedge clk); #1;
        cyc[d] = 1; WE = we; drive_beat(adr, 0, nb, dbase);
        while (!done && t < 60) begin
            @(negedge clk);
            hit = term(d) != 0;
            if (hit) begin
                score(d, t);
                k++;
                done = err[d] || k == nb;
            end else if (gl > 0) check("gap_no_ack", 32'(ack[d]), 0);
            t++;
            @(posedge clk); #1;
            if (done) STB = 0;
            else if (gl > 0) begin gl--; if (gl == 0) drive_beat(adr, k, nb, dbase); end
            else if (hit && k == gap && !gapped) begin STB = 0; gl = 2; gapped = 1; end
            else if (hit) drive_beat(adr, k, nb, dbase);
        end
        if (!done) begin
            chk_cnt++;
            $display("FAIL burst_timeout: %0d beats terminated, required %0d", k, nb);
            sb.delete();
            STB = 0;
        end
        @(negedge clk); check("burst_idle", 32'(term(d)), 0);
        @(posedge clk); #1; cyc[d] = 0;
    endtask

    initial begin
        vecs[0]  = vec_t'{0, 1, 32'h10,       32'hDEADBEEF, 2'd1, 32'h0,        1};
        vecs[1]  = vec_t'{0, 0, 32'h10,       32'h0,        2'd1, 32'hDEADBEEF, 1};
        vecs[2]  = vec_t'{0, 0, 32'h13,       32'h0,        2'd1, 32'hDEADBEEF, 1};
        vecs[3]  = vec_t'{0, 1, 32'hFFC,      32'hCAFEF00D, 2'd1, 32'h0,        1};
        vecs[4]  = vec_t'{0, 0, 32'hFFC,      32'h0,        2'd1, 32'hCAFEF00D, 1};
        vecs[5]  = vec_t'{0, 0, 32'h1000,     32'h0,        2'd2, 32'h0,        1};
        vecs[6]  = vec_t'{0, 1, 32'h1010,     32'hBAD00BAD, 2'd2, 32'h0,        1};
        vecs[7]  = vec_t'{0, 0, 32'h10,       32'h0,        2'd1, 32'hDEADBEEF, 1};
        vecs[8]  = vec_t'{1, 1, 32'h0,        32'h12345678, 2'd1, 32'h0,        4};
        vecs[9]  = vec_t'{1, 0, 32'h0,        32'h0,        2'd1, 32'h12345678, 4};
        vecs[10] = vec_t'{1, 0, 32'hFFFFFFFC, 32'h0,        2'd2, 32'h0,        4};
        vecs[11] = vec_t'{2, 1, 32'h40,       32'h11111111, 2'd1, 32'h0,        6};
        vecs[12] = vec_t'{2, 0, 32'h40,       32'h0,        2'd1, 32'h11111111, 6};

        cyc = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_term", 32'(term(i)), 0);
            check("reset_dat", dat[i], 0);
        end
        @(posedge clk); #1; rst = 0; cyc = 0;

        foreach (vecs[i]) classic(vecs[i]);

        burst(0, 1, 32'h20, 4, 4, 0, 1);
        burst(0, 0, 32'h20, 4, 4, 0, 1);
        burst(0, 0, 32'h20, 4, 4, 2, 1);
        burst(0, 1, 32'hFF8, 3, 2, 0, 32'h100);
        burst(0, 0, 32'hFF8, 3, 2, 0, 32'h100);

        @(posedge clk); #1;
        cyc[2] = 1; STB = 1; WE = 1; ADR = 32'h40; DAT_O = 32'h22222222; CTI_O = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("abort_wait", 32'(term(2)), 0);
            @(posedge clk); #1;
        end
        cyc[2] = 0; STB = 0;
        repeat (4) begin @(negedge clk); check("abort_idle", 32'(term(2)), 0); end
        classic(vec_t'{2, 0, 32'h40, 32'h0, 2'd1, 32'h11111111, 6});

        @(posedge clk); #1;
        cyc[0] = 1; STB = 1; WE = 0; ADR = 32'h20; CTI_O = 3'b010;
        @(negedge clk);
        @(negedge clk); check("rst_beat0_ack", 32'(ack[0]), 1); check("rst_beat0_dat", dat[0], 1);
        @(posedge clk); #1; ADR = 32'h24;
        @(negedge clk); check("rst_beat1_ack", 32'(ack[0]), 1); check("rst_beat1_dat", dat[0], 2);
        @(posedge clk); #1; ADR = 32'h28; rst = 1;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check("rst_mid_term", 32'(term(0)), 0);
        check("rst_mid_dat", dat[0], 0);
        @(posedge clk); #1; cyc[0] = 0; STB = 0;
        repeat (2) @(posedge clk);

        check("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
